seg_display_arbiter: RTL and testbench
======================================

# seg_display_arbiter

Shares the four-digit seven-segment display between two requesters: a high-priority channel (alarm/status) and a low-priority channel (normal readout). It grants ownership by request/grant handshake, enforces a minimum on-screen hold time before preemption, and drives the four 4-bit digit inputs of the display top level. It sits between the application logic and the display driver.

## Interface
- TICK_DIV, 100000: clk cycles per hold tick (1 ms at 100 MHz); ≥ 1
- HOLD_TICKS, 500: ticks the low-priority owner keeps the display before it can be preempted; 0 allowed
- clk  in  1  system clock, all logic on rising edge
- clr  in  1  reset; one clock; synchronous and active-high
- req0  in  1  high-priority request; level, held while display wanted
- data0  in  16  high-priority digits; [3:0]→dig1 … [15:12]→dig4
- req1  in  1  low-priority request; level
- data1  in  16  low-priority digits, same packing
- gnt0  out  1  channel 0 owns display
- gnt1  out  1  channel 1 owns display
- dig1, dig2, dig3, dig4  out  4 each  digit values to display top level
- blank  out  1  high when no owner; top level disables all anodes

## Operation
- States: IDLE, OWN0, OWN1. gnt0 = (state==OWN0), gnt1 = (state==OWN1), blank = (state==IDLE); all registered.
- IDLE: req0 → OWN0; else req1 → OWN1; else stay.
- OWN0: stay while req0; on req0 low → OWN1 if req1, else IDLE. req1 never preempts.
- OWN1: req0 && hold_done → OWN0 (preempt, no gap cycle); else req1 low → OWN0 if req0, else IDLE; else stay. req0 before hold_done waits.
- Preempted channel 1 keeps req1 high to regain display; it is granted on the edge that releases OWN0.
- Digits: on every edge, if next state is OWN0 load data0, if OWN1 load data1, if IDLE load 0. Owner data changes reach digits with 1-cycle latency.
- Hold timer: prescaler counts 0..TICK_DIV-1, tick when at TICK_DIV-1; hold_cnt increments on tick, saturates at HOLD_TICKS; hold_done = (hold_cnt == HOLD_TICKS). Prescaler and hold_cnt clear on every edge where state changes and while in IDLE; they run in OWN0 and OWN1.
- Widths: prescaler $clog2(TICK_DIV) bits (min 1), hold_cnt $clog2(HOLD_TICKS+1) bits (min 1); no wrap past saturation.

## Timing
- Reset: state IDLE, gnt0=gnt1=0, blank=1, dig1..dig4=0, counters 0. clr mid-ownership drops grant and blanks on the same edge; clr wins over all requests.
- Grant latency: request sampled at edge E → gnt and digits valid after E (1 cycle). gnt0 and gnt1 never both high.
- Release: req low sampled at edge E → gnt low after E.
- Preemption: entry to OWN1 at edge E0 → hold_done true after edge E0 + HOLD_TICKS·TICK_DIV; with req0 held, switch at edge E0 + HOLD_TICKS·TICK_DIV + 1. HOLD_TICKS=0 → switch at E0+1.
- Simultaneous req0 and req1 from IDLE → OWN0.
- Simultaneous req1 drop and preemption in OWN1 → OWN0.

## Structure
- Package seg_disp_pkg: state enum (IDLE, OWN0, OWN1), digit packing constants (DIG_W=4, NUM_DIG=4).
- One sub-module: hold_timer (prescaler + saturating hold_cnt, inputs clk/clr/run/restart, output hold_done).
- Outputs connect to dig1..dig4 of the four-digit display top; blank gates its AN.

## Test plan
- Reset: apply clr for 1 cycle during OWN1 → next cycle gnt1=0, blank=1, digits 0.
- Basic grant: TICK_DIV=4, HOLD_TICKS=2; req1=1, data1=16'h1234 → 1 cycle later gnt1=1, dig4..dig1=1,2,3,4; drop req1 → next cycle blank=1, digits 0.
- Priority tie: req0=req1=1 in IDLE, data0=16'hDEAD → gnt0=1 only, digits D,E,A,D.
- Hold-time preemption: OWN1 entered at E0, req0 raised at E0+2 → gnt1 stays until switch at E0+9; gnt0=1 with data0 digits, no blank cycle.
- Return after preemption: req1 held while owned by 0; drop req0 → next cycle gnt1=1, data1 digits.
- HOLD_TICKS=0: req0 raised one cycle after gnt1 → switch on next edge; data change in OWN0 visible 1 cycle later.

Source files
------------

// File: rtl/seg_disp_pkg.sv
// Shared types and digit packing constants for the seven-segment display arbiter.
package seg_disp_pkg;

    localparam int DIG_W   = 4;
    localparam int NUM_DIG = 4;
    localparam int DATA_W  = DIG_W * NUM_DIG;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

endpackage

// File: rtl/seg_display_arbiter_hold_timer.sv
// Minimum on-screen hold timer: a prescaler producing ticks and a saturating tick counter.
module hold_timer #(
    parameter int TICK_DIV   = 100000,
    parameter int HOLD_TICKS = 500
) (
    input  logic i_clk,
    input  logic i_clr,
    input  logic i_run,
    input  logic i_restart,
    output logic o_hold_done
);

    localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int CNT_W = (HOLD_TICKS > 0) ? $clog2(HOLD_TICKS + 1) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(HOLD_TICKS);

    logic [PRE_W-1:0] r_pre;
    logic [CNT_W-1:0] r_cnt;
    logic             w_tick;

    assign w_tick      = (r_pre == PRE_LAST);
    assign o_hold_done = (r_cnt == CNT_MAX);

    // Counting restarts from zero on every ownership change so each owner gets a fresh hold window.
    always_ff @(posedge i_clk) begin
        if (i_clr || i_restart || !i_run) begin
            r_pre <= '0;
            r_cnt <= '0;
        end else begin
            r_pre <= w_tick ? '0 : r_pre + 1'b1;
            if (w_tick && (r_cnt != CNT_MAX)) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/seg_display_arbiter.sv
// Grants the four-digit display to a high-priority or low-priority requester, with a minimum
// hold time protecting the low-priority owner from immediate preemption.
import seg_disp_pkg::*;

module seg_display_arbiter #(
    parameter int TICK_DIV   = 100000,
    parameter int HOLD_TICKS = 500
) (
    input  logic        i_clk,
    input  logic        i_clr,
    input  logic        i_req0,
    input  logic [15:0] i_data0,
    input  logic        i_req1,
    input  logic [15:0] i_data1,
    output logic        o_gnt0,
    output logic        o_gnt1,
    output logic [3:0]  o_dig1,
    output logic [3:0]  o_dig2,
    output logic [3:0]  o_dig3,
    output logic [3:0]  o_dig4,
    output logic        o_blank
);

    state_t            r_state;
    state_t            w_next;
    logic [DATA_W-1:0] r_digits;
    logic [DATA_W-1:0] w_next_digits;
    logic              w_hold_done;
    logic              w_run;
    logic              w_restart;

    assign w_run     = (r_state != IDLE);
    assign w_restart = (w_next != r_state);

    hold_timer #(
        .TICK_DIV   (TICK_DIV),
        .HOLD_TICKS (HOLD_TICKS)
    ) u_hold_timer (
        .i_clk       (i_clk),
        .i_clr       (i_clr),
        .i_run       (w_run),
        .i_restart   (w_restart),
        .o_hold_done (w_hold_done)
    );

    // Channel 1 only loses the display once its hold window is over; channel 0 is never preempted.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (i_req0) begin
                    w_next = OWN0;
                end else if (i_req1) begin
                    w_next = OWN1;
                end
            end
            OWN0: begin
                if (!i_req0) begin
                    w_next = i_req1 ? OWN1 : IDLE;
                end
            end
            OWN1: begin
                if (i_req0 && w_hold_done) begin
                    w_next = OWN0;
                end else if (!i_req1) begin
                    w_next = i_req0 ? OWN0 : IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        w_next_digits = '0;
        case (w_next)
            OWN0:    w_next_digits = i_data0;
            OWN1:    w_next_digits = i_data1;
            default: w_next_digits = '0;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_clr) begin
            r_state  <= IDLE;
            r_digits <= '0;
        end else begin
            r_state  <= w_next;
            r_digits <= w_next_digits;
        end
    end

    assign o_gnt0  = (r_state == OWN0);
    assign o_gnt1  = (r_state == OWN1);
    assign o_blank = (r_state == IDLE);
    assign o_dig1  = r_digits[3:0];
    assign o_dig2  = r_digits[7:4];
    assign o_dig3  = r_digits[11:8];
    assign o_dig4  = r_digits[15:12];

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Directed bench for seg_display_arbiter: one instance with a 2-tick hold window, one with none.
module tb_seg_display_arbiter;

    logic        clk;
    logic        clr;
    logic        aReq0, aReq1, bReq0, bReq1;
    logic [15:0] aData0, aData1, bData0, bData1;
    logic        aGnt0, aGnt1, aBlank, bGnt0, bGnt1, bBlank;
    logic [3:0]  aDig1, aDig2, aDig3, aDig4, bDig1, bDig2, bDig3, bDig4;

    int nChecks = 0;
    int nPass   = 0;
    int nFail   = 0;

    seg_display_arbiter #(.TICK_DIV(4), .HOLD_TICKS(2)) u_dutA (
        .i_clk(clk), .i_clr(clr),
        .i_req0(aReq0), .i_data0(aData0), .i_req1(aReq1), .i_data1(aData1),
        .o_gnt0(aGnt0), .o_gnt1(aGnt1),
        .o_dig1(aDig1), .o_dig2(aDig2), .o_dig3(aDig3), .o_dig4(aDig4),
        .o_blank(aBlank)
    );

    seg_display_arbiter #(.TICK_DIV(4), .HOLD_TICKS(0)) u_dutB (
        .i_clk(clk), .i_clr(clr),
        .i_req0(bReq0), .i_data0(bData0), .i_req1(bReq1), .i_data1(bData1),
        .o_gnt0(bGnt0), .o_gnt1(bGnt1),
        .o_dig1(bDig1), .o_dig2(bDig2), .o_dig3(bDig3), .o_dig4(bDig4),
        .o_blank(bBlank)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        nChecks++;
        assert (observed === expected) nPass++;
        else begin
            nFail++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Packs grant/blank as {gnt0,gnt1,blank} for compact comparisons.
    function automatic logic [31:0] aStat();
        return {29'd0, aGnt0, aGnt1, aBlank};
    endfunction

    function automatic logic [31:0] bStat();
        return {29'd0, bGnt0, bGnt1, bBlank};
    endfunction

    initial begin
        clr = 1'b1;
        aReq0 = 0; aReq1 = 0; aData0 = '0; aData1 = '0;
        bReq0 = 0; bReq1 = 0; bData0 = '0; bData1 = '0;
        applyStimulus(1);
        checkOutput("reset_stat", aStat(), 32'b001);
        checkOutput("reset_digits", {16'd0, aDig4, aDig3, aDig2, aDig1}, 32'h0);
        clr = 1'b0;

        aReq1 = 1; aData1 = 16'h1234;
        applyStimulus(1);
        checkOutput("grant1_stat", aStat(), 32'b010);
        checkOutput("grant1_digits", {16'd0, aDig4, aDig3, aDig2, aDig1}, 32'h1234);

        aReq1 = 0;
        applyStimulus(1);
        checkOutput("release1_stat", aStat(), 32'b001);
        checkOutput("release1_digits", {16'd0, aDig4, aDig3, aDig2, aDig1}, 32'h0);

        aReq0 = 1; aReq1 = 1; aData0 = 16'hDEAD;
        applyStimulus(1);
        checkOutput("tie_stat", aStat(), 32'b100);
        checkOutput("tie_digits", {16'd0, aDig4, aDig3, aDig2, aDig1}, 32'hDEAD);

        aReq0 = 0; aReq1 = 0;
        applyStimulus(1);
        checkOutput("idle_again", aStat(), 32'b001);

        // Edge E0 enters OWN1; req0 rises so that it is first sampled at E0+2.
        aReq1 = 1;
        applyStimulus(1);
        checkOutput("e0_stat", aStat(), 32'b010);
        applyStimulus(1);
        aReq0 = 1; aData0 = 16'hCAFE;
        for (int k = 2; k <= 8; k++) begin
            applyStimulus(1);
            checkOutput($sformatf("hold_wait_e%0d", k), aStat(), 32'b010);
        end
        applyStimulus(1);
        checkOutput("preempt_stat", aStat(), 32'b100);
        checkOutput("preempt_digits", {16'd0, aDig4, aDig3, aDig2, aDig1}, 32'hCAFE);

        aData0 = 16'hBEEF;
        applyStimulus(1);
        checkOutput("own0_data_change", {16'd0, aDig4, aDig3, aDig2, aDig1}, 32'hBEEF);

        aReq0 = 0;
        applyStimulus(1);
        checkOutput("return1_stat", aStat(), 32'b010);
        checkOutput("return1_digits", {16'd0, aDig4, aDig3, aDig2, aDig1}, 32'h1234);

        clr = 1'b1;
        applyStimulus(1);
        checkOutput("clr_mid_own1_stat", aStat(), 32'b001);
        checkOutput("clr_mid_own1_digits", {16'd0, aDig4, aDig3, aDig2, aDig1}, 32'h0);
        clr = 1'b0;
        aReq1 = 0;

        bReq1 = 1; bData1 = 16'h5678;
        applyStimulus(1);
        checkOutput("b_grant1_stat", bStat(), 32'b010);
        bReq0 = 1; bData0 = 16'h9ABC;
        applyStimulus(1);
        checkOutput("b_preempt_stat", bStat(), 32'b100);
        checkOutput("b_preempt_digits", {16'd0, bDig4, bDig3, bDig2, bDig1}, 32'h9ABC);
        bData0 = 16'h1111;
        applyStimulus(1);
        checkOutput("b_data_change", {16'd0, bDig4, bDig3, bDig2, bDig1}, 32'h1111);

        bReq0 = 0;
        applyStimulus(1);
        checkOutput("b_return1_stat", bStat(), 32'b010);
        checkOutput("b_return1_digits", {16'd0, bDig4, bDig3, bDig2, bDig1}, 32'h5678);
        bReq1 = 0; bReq0 = 1;
        applyStimulus(1);
        checkOutput("b_drop_and_preempt", bStat(), 32'b100);
        bReq0 = 0;
        applyStimulus(1);
        checkOutput("b_final_idle", bStat(), 32'b001);
        checkOutput("b_final_digits", {16'd0, bDig4, bDig3, bDig2, bDig1}, 32'h0);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
